// File: rtl/t07_tft_pkg.sv
// Shared types for the SPI TFT master: MMIO op codes, queued FIFO entry, serialiser states.
// Also holds the helper that turns an accepted MMIO write into a FIFO entry.
package t07_tft_pkg;

    typedef enum logic [1:0] {
        CMD    = 2'd0,
        DATA8  = 2'd1,
        DATA16 = 2'd2,
        CTRL   = 2'd3
    } tft_op_e;

    typedef struct packed {
        logic        dc;
        logic        two_bytes;
        logic [15:0] data;
    } tft_entry_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2,
        HOLD  = 2'd3
    } tft_state_e;

    // Single-byte ops keep their byte in data[7:0]; the halfword op sends data[15:8] first.
    function automatic tft_entry_t makeEntry(input tft_op_e op, input logic [15:0] payload);
        tft_entry_t entry;
        entry.dc        = (op != CMD);
        entry.two_bytes = (op == DATA16);
        entry.data      = (op == DATA16) ? payload : {8'h00, payload[7:0]};
        return entry;
    endfunction

endpackage

// File: rtl/t07_tft_fifo.sv
// Synchronous FIFO of tft_entry_t; head entry is visible combinationally on popData.
// Pointers carry one extra wrap bit so full/empty are told apart by the MSB.
module t07_tft_fifo
    import t07_tft_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  tft_entry_t pushData,
    input  logic       pop,
    output tft_entry_t popData,
    output logic       full,
    output logic       empty
);

    localparam int PW = $clog2(DEPTH);

    tft_entry_t     mem [DEPTH];
    logic [PW:0]    wrPtrReg;
    logic [PW:0]    rdPtrReg;
    logic           doPush;
    logic           doPop;

    assign doPush = push && !full;
    assign doPop  = pop && !empty;

    always_ff @(posedge clk) begin
        if (doPush) begin
            mem[wrPtrReg[PW-1:0]] <= pushData;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wrPtrReg <= '0;
            rdPtrReg <= '0;
        end else begin
            if (doPush) begin
                wrPtrReg <= wrPtrReg + 1'b1;
            end
            if (doPop) begin
                rdPtrReg <= rdPtrReg + 1'b1;
            end
        end
    end

    assign empty   = (wrPtrReg == rdPtrReg);
    assign full    = (wrPtrReg[PW] != rdPtrReg[PW]) && (wrPtrReg[PW-1:0] == rdPtrReg[PW-1:0]);
    assign popData = mem[rdPtrReg[PW-1:0]];

endmodule

// File: rtl/t07_spi_tft_master.sv
// MMIO-to-SPI bridge for a TFT panel: queues writes, acks each one, and shifts them out as
// SPI mode-0 bytes with a DC line. Optional panel reset output when T07_TFT_RESET_EN is defined.
module t07_spi_tft_master
    import t07_tft_pkg::*;
#(
    parameter int CLK_DIV    = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wi_in,
    input  logic [31:0] addr_in,
    input  logic [31:0] data_in,
    output logic        ack_out,
    output logic        busy_out,
    output logic        spi_sck,
    output logic        spi_mosi,
    output logic        spi_cs_n,
    output logic        spi_dc
`ifdef T07_TFT_RESET_EN
    ,
    output logic        tft_rst_n
`endif
);

    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] DIV_LAST = CW'(CLK_DIV - 1);

    tft_state_e     stateReg, stateNext;
    logic [CW-1:0]  divCntReg, divCntNext;
    logic [2:0]     bitCntReg, bitCntNext;
    logic [7:0]     shiftReg, shiftNext;
    logic [7:0]     lowByteReg, lowByteNext;
    logic           lowPendReg, lowPendNext;
    logic           sckReg, sckNext;
    logic           mosiReg, mosiNext;
    logic           csNReg, csNNext;
    logic           dcReg, dcNext;
    logic           ackReg;

    tft_op_e        opSel;
    tft_entry_t     pushEntry;
    tft_entry_t     headEntry;
    logic           accept;
    logic           push;
    logic           pop;
    logic           fifoFull;
    logic           fifoEmpty;
    logic           unusedBits;

    assign opSel     = tft_op_e'(addr_in[3:2]);
    assign pushEntry = makeEntry(opSel, data_in[15:0]);
    // A request is held until acked, so the ack cycle itself must not accept it again.
    assign accept    = wi_in && !ackReg && !fifoFull;
    assign push      = accept && (opSel != CTRL);
    assign unusedBits = ^{addr_in[31:4], addr_in[1:0], data_in[31:16]};

    t07_tft_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (push),
        .pushData(pushEntry),
        .pop     (pop),
        .popData (headEntry),
        .full    (fifoFull),
        .empty   (fifoEmpty)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ackReg <= 1'b0;
        end else begin
            ackReg <= accept;
        end
    end

`ifdef T07_TFT_RESET_EN
    logic tftRstNReg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tftRstNReg <= 1'b0;
        end else if (accept && (opSel == CTRL)) begin
            tftRstNReg <= data_in[0];
        end
    end

    assign tft_rst_n = tftRstNReg;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stateReg   <= IDLE;
            divCntReg  <= '0;
            bitCntReg  <= 3'd0;
            shiftReg   <= 8'h00;
            lowByteReg <= 8'h00;
            lowPendReg <= 1'b0;
            sckReg     <= 1'b0;
            mosiReg    <= 1'b0;
            csNReg     <= 1'b1;
            dcReg      <= 1'b0;
        end else begin
            stateReg   <= stateNext;
            divCntReg  <= divCntNext;
            bitCntReg  <= bitCntNext;
            shiftReg   <= shiftNext;
            lowByteReg <= lowByteNext;
            lowPendReg <= lowPendNext;
            sckReg     <= sckNext;
            mosiReg    <= mosiNext;
            csNReg     <= csNNext;
            dcReg      <= dcNext;
        end
    end

    always_comb begin
        stateNext   = stateReg;
        divCntNext  = divCntReg;
        bitCntNext  = bitCntReg;
        shiftNext   = shiftReg;
        lowByteNext = lowByteReg;
        lowPendNext = lowPendReg;
        sckNext     = sckReg;
        mosiNext    = mosiReg;
        csNNext     = csNReg;
        dcNext      = dcReg;
        pop         = 1'b0;

        case (stateReg)
            IDLE: begin
                if (!fifoEmpty) begin
                    stateNext = LOAD;
                end
            end

            LOAD: begin
                pop        = 1'b1;
                csNNext    = 1'b0;
                dcNext     = headEntry.dc;
                divCntNext = '0;
                bitCntNext = 3'd0;
                sckNext    = 1'b0;
                stateNext  = SHIFT;
                if (headEntry.two_bytes) begin
                    shiftNext   = headEntry.data[15:8];
                    lowByteNext = headEntry.data[7:0];
                    lowPendNext = 1'b1;
                    mosiNext    = headEntry.data[15];
                end else begin
                    shiftNext   = headEntry.data[7:0];
                    lowPendNext = 1'b0;
                    mosiNext    = headEntry.data[7];
                end
            end

            SHIFT: begin
                if (divCntReg == DIV_LAST) begin
                    divCntNext = '0;
                    sckNext    = !sckReg;
                    // Everything below happens on the falling SCK edge (mode 0).
                    if (sckReg) begin
                        if (bitCntReg == 3'd7) begin
                            bitCntNext = 3'd0;
                            if (lowPendReg) begin
                                shiftNext   = lowByteReg;
                                mosiNext    = lowByteReg[7];
                                lowPendNext = 1'b0;
                            end else if (!fifoEmpty) begin
                                stateNext = LOAD;
                            end else begin
                                stateNext = HOLD;
                            end
                        end else begin
                            bitCntNext = bitCntReg + 3'd1;
                            shiftNext  = {shiftReg[6:0], 1'b0};
                            mosiNext   = shiftReg[6];
                        end
                    end
                end else begin
                    divCntNext = divCntReg + 1'b1;
                end
            end

            HOLD: begin
                if (divCntReg == DIV_LAST) begin
                    divCntNext = '0;
                    csNNext    = 1'b1;
                    stateNext  = IDLE;
                end else begin
                    divCntNext = divCntReg + 1'b1;
                end
            end

            default: begin
                stateNext = IDLE;
            end
        endcase
    end

    assign ack_out  = ackReg;
    assign busy_out = !fifoEmpty || (stateReg != IDLE);
    assign spi_sck  = sckReg;
    assign spi_mosi = mosiReg;
    assign spi_cs_n = csNReg;
    assign spi_dc   = dcReg;

endmodule

// File: tb/tb_t07_spi_tft_master.sv
// Scoreboard bench for t07_spi_tft_master: writes push expected {dc,byte} entries, an SPI
// monitor decodes bytes at SCK rises and pops/compares. Build with T07_TFT_RESET_EN for the panel reset port.
module tb_t07_spi_tft_master;

    localparam int CLK_DIV = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wiIn = 1'b0;
    logic [31:0] addrIn = 32'd0;
    logic [31:0] dataIn = 32'd0;
    logic        ackOut;
    logic        busyOut;
    logic        spiSck;
    logic        spiMosi;
    logic        spiCsN;
    logic        spiDc;
`ifdef T07_TFT_RESET_EN
    logic        tftRstN;
`endif

    int checks = 0;
    int errors = 0;

    logic [8:0] expQ[$];

    t07_spi_tft_master #(
        .CLK_DIV   (CLK_DIV),
        .FIFO_DEPTH(4)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .wi_in    (wiIn),
        .addr_in  (addrIn),
        .data_in  (dataIn),
        .ack_out  (ackOut),
        .busy_out (busyOut),
        .spi_sck  (spiSck),
        .spi_mosi (spiMosi),
        .spi_cs_n (spiCsN),
        .spi_dc   (spiDc)
`ifdef T07_TFT_RESET_EN
        ,
        .tft_rst_n(tftRstN)
`endif
    );

    always #5 clk = !clk;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, actual, expected);
        end
    endtask

    // ---------------- SPI monitor / scoreboard consumer ----------------
    logic       prevSck = 1'b0;
    logic       prevCsN = 1'b1;
    int         cycleCnt = 0;
    int         lastFallCycle = 0;
    int         bitIdx = 0;
    int         totalRises = 0;
    int         windows = 0;
    logic [7:0] rxByte = 8'h00;
    logic       rxDc = 1'b0;
    logic       dcBad = 1'b0;

    always @(negedge clk) begin
        cycleCnt++;
        if (rst) begin
            bitIdx = 0;
            dcBad  = 1'b0;
        end else begin
            if (spiSck && !prevSck) begin
                totalRises++;
                check("cs_low_at_sck_rise", {31'd0, spiCsN}, 32'd0);
                if (bitIdx == 0) rxDc = spiDc;
                else if (spiDc != rxDc) dcBad = 1'b1;
                rxByte = {rxByte[6:0], spiMosi};
                bitIdx++;
                if (bitIdx == 8) begin
                    bitIdx = 0;
                    $display("BYTE dc=%0d val=%02h", rxDc, rxByte);
                    check("dc_stable_in_byte", {31'd0, dcBad}, 32'd0);
                    dcBad = 1'b0;
                    if (expQ.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL spi_byte_unexpected actual=%0h required=none", {rxDc, rxByte});
                    end else begin
                        check("spi_byte", {23'd0, rxDc, rxByte}, {23'd0, expQ.pop_front()});
                    end
                end
            end
            if (!spiSck && prevSck) lastFallCycle = cycleCnt;
            if (!spiCsN && prevCsN) windows++;
            if (spiCsN && !prevCsN) check("cs_hold_after_last_fall", cycleCnt - lastFallCycle, CLK_DIV);
        end
        prevSck = spiSck;
        prevCsN = spiCsN;
    end

    // ---------------- stimulus ----------------
    task automatic pushExp(input logic [1:0] op, input logic [31:0] data);
        case (op)
            2'd0: expQ.push_back({1'b0, data[7:0]});
            2'd1: expQ.push_back({1'b1, data[7:0]});
            2'd2: begin
                expQ.push_back({1'b1, data[15:8]});
                expQ.push_back({1'b1, data[7:0]});
            end
            default: ;
        endcase
    endtask

    // Called just after a negedge; returns on the negedge where ack_out is seen.
    task automatic doWrite(input logic [1:0] op, input logic [31:0] data, output int waitCycles);
        addrIn = {28'd0, op, 2'b00};
        dataIn = data;
        wiIn   = 1'b1;
        waitCycles = 0;
        do begin
            @(negedge clk);
            waitCycles++;
        end while (!ackOut && waitCycles < 2000);
        if (!ackOut) begin
            checks++;
            errors++;
            $display("FAIL ack_timeout actual=none required=ack op=%0d", op);
        end else begin
            pushExp(op, data);
        end
        wiIn = 1'b0;
        $display("WRITE op=%0d data=%08h ack_wait=%0d", op, data, waitCycles);
    endtask

    task automatic waitIdle(input string name);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while ((busyOut || !spiCsN) && n < 5000);
        check({name, "_idle_timeout"}, {31'd0, (busyOut || !spiCsN)}, 32'd0);
        @(negedge clk);
        check({name, "_drained"}, expQ.size(), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        int rises0;
        int win0;
        int acks;
        int waits[6];
        logic [1:0]  burstOp[6]   = '{2'd0, 2'd1, 2'd2, 2'd1, 2'd0, 2'd1};
        logic [31:0] burstData[6] = '{32'h11, 32'h22, 32'h3344, 32'h55, 32'h66, 32'h77};

        // Reset values
        repeat (2) @(negedge clk);
        check("rst_ack", {31'd0, ackOut}, 32'd0);
        check("rst_busy", {31'd0, busyOut}, 32'd0);
        check("rst_sck", {31'd0, spiSck}, 32'd0);
        check("rst_mosi", {31'd0, spiMosi}, 32'd0);
        check("rst_cs_n", {31'd0, spiCsN}, 32'd1);
        check("rst_dc", {31'd0, spiDc}, 32'd0);
`ifdef T07_TFT_RESET_EN
        check("rst_tft_rst_n", {31'd0, tftRstN}, 32'd0);
`endif
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Op 0 byte 0x2A: latency of ack, cs_n and first SCK rise
        doWrite(2'd0, 32'h2A, w);
        check("op0_ack_latency", w, 1);
        check("op0_cs_still_high", {31'd0, spiCsN}, 32'd1);
        @(negedge clk);
        check("op0_cs_in_load", {31'd0, spiCsN}, 32'd1);
        @(negedge clk);
        check("op0_cs_low", {31'd0, spiCsN}, 32'd0);
        check("op0_dc_cmd", {31'd0, spiDc}, 32'd0);
        @(negedge clk);
        check("op0_sck_before_rise", {31'd0, spiSck}, 32'd0);
        @(negedge clk);
        check("op0_first_sck_rise", {31'd0, spiSck}, 32'd1);
        waitIdle("op0");

        // Op 2 halfword 0xF81F: one window, 16 rises
        rises0 = totalRises;
        win0   = windows;
        doWrite(2'd2, 32'h0000F81F, w);
        waitIdle("op2");
        check("op2_sck_rises", totalRises - rises0, 16);
        check("op2_cs_windows", windows - win0, 1);

        // Back-to-back burst beyond FIFO depth
        win0 = windows;
        for (int i = 0; i < 6; i++) begin
            doWrite(burstOp[i], burstData[i], w);
            waits[i] = w;
        end
        check("burst_full_stalls_ack", {31'd0, (waits[5] > 4)}, 32'd1);
        waitIdle("burst");
        check("burst_cs_windows", windows - win0, 1);

        // wi_in held three cycles past the ack
        addrIn = {28'd0, 2'd1, 2'b00};
        dataIn = 32'h5A;
        wiIn   = 1'b1;
        acks   = 0;
        w      = 0;
        do begin
            @(negedge clk);
            w++;
        end while (!ackOut && w < 100);
        if (ackOut) begin
            acks++;
            pushExp(2'd1, 32'h5A);
        end
        repeat (3) begin
            @(negedge clk);
            if (ackOut) begin
                acks++;
                pushExp(2'd1, 32'h5A);
            end
        end
        wiIn = 1'b0;
        $display("WRITE op=1 data=0000005a held acks=%0d", acks);
        check("hold_ack_count", acks, 2);
        waitIdle("hold");

        // Op 3 control write: acked, no SPI activity
        rises0 = totalRises;
        win0   = windows;
        doWrite(2'd3, 32'h1, w);
        check("op3_ack_latency", w, 1);
`ifdef T07_TFT_RESET_EN
        check("op3_tft_rst_n", {31'd0, tftRstN}, 32'd1);
`endif
        repeat (10) @(negedge clk);
        check("op3_no_busy", {31'd0, busyOut}, 32'd0);
        check("op3_no_sck", totalRises - rises0, 0);
        check("op3_no_cs", windows - win0, 0);

        // Async reset in the middle of a byte
        doWrite(2'd1, 32'hFF, w);
        w = 0;
        while (bitIdx != 4 && w < 500) begin
            @(negedge clk);
            w++;
        end
        check("midshift_reached_bit4", bitIdx, 4);
        #1 rst = 1'b1;
        #1;
        check("midshift_cs_n", {31'd0, spiCsN}, 32'd1);
        check("midshift_sck", {31'd0, spiSck}, 32'd0);
        check("midshift_busy", {31'd0, busyOut}, 32'd0);
`ifdef T07_TFT_RESET_EN
        check("midshift_tft_rst_n", {31'd0, tftRstN}, 32'd0);
`endif
        expQ.delete();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        rises0 = totalRises;
        repeat (40) @(negedge clk);
        check("post_reset_no_sck", totalRises - rises0, 0);
        check("post_reset_busy", {31'd0, busyOut}, 32'd0);

        // Recovery after reset
        doWrite(2'd1, 32'hA5, w);
        waitIdle("recover");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
